ps2_keyboard_frontend: RTL and testbench

// - PS/2 keyboard receive front-end for the board top level.
// - Synchronises PS2_CLK/PS2_DAT to the 50 MHz clock and deserialises 11-bit device-to-host frames.
// - Filters break/extended prefixes, holds the last make code, and drives two active-low 7-segment digits showing it in hex.
// - Also generates a delayed power-on/reset release (dly_rst) for downstream PLL/VGA logic.

---
 rtl/ps2_keyboard_frontend_if.sv | 29 ++
 rtl/ps2_keyboard_frontend.sv | 160 ++++++++++++++++
 tb/tb_ps2_keyboard_frontend.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_frontend_if.sv
// PS/2 keyboard front-end bundle: raw PS/2 lines in, decoded key/status/display signals out.
// Latency: none (wiring only).
// Backpressure: none; every output is either a level or a single-cycle pulse.
// Ports: ps2_clk/ps2_dat (raw, asynchronous), key_data/last_key (bytes), byte_valid/key_pressed/frame_err (pulses),
//        hex0/hex1 (active-low 7-seg), dly_rst (delayed reset release).
interface ps2_keyboard_frontend_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] key_data;
    logic       byte_valid;
    logic       key_pressed;
    logic [7:0] last_key;
    logic       frame_err;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic       dly_rst;

    // master: the front-end itself
    modport master (
        input  ps2_clk, ps2_dat,
        output key_data, byte_valid, key_pressed, last_key, frame_err, hex0, hex1, dly_rst
    );

    // slave: the board logic / keyboard side
    modport slave (
        output ps2_clk, ps2_dat,
        input  key_data, byte_valid, key_pressed, last_key, frame_err, hex0, hex1, dly_rst
    );
endinterface

// File: rtl/ps2_keyboard_frontend.sv
// PS/2 keyboard receiver: sync + deserialise 11-bit frames, prefix filter, hex display, delayed reset release.
// Latency: pulses appear 1 cycle after the stop-bit falling edge is seen (3 cycles after the raw edge via the syncs).
// Backpressure: none; consumers must take single-cycle pulses as they come.
// Ports: clk (rising edge), RESETN (async, active-high), kbd (master modport of ps2_keyboard_frontend_if).
module ps2_keyboard_frontend #(
    parameter int TIMEOUT_CYCLES     = 50000,
    parameter int RESET_DELAY_CYCLES = 1048575
) (
    input  logic                           clk,
    input  logic                           RESETN,
    ps2_keyboard_frontend_if.master        kbd
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(RESET_DELAY_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    clk_sync_q;      // [0],[1] synchroniser, [2] previous synced value for edge detect
    logic [1:0]    dat_sync_q;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          brk_q, brk_d;
    logic [7:0]    key_data_q, key_data_d;
    logic [7:0]    last_key_q, last_key_d;
    logic          byte_valid_q, byte_valid_d;
    logic          key_pressed_q, key_pressed_d;
    logic          frame_err_q, frame_err_d;
    logic [RW-1:0] dly_cnt_q, dly_cnt_d;

    logic ps2_fall;
    logic ps2_bit;

    assign ps2_fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign ps2_bit  = dat_sync_q[1];

    always_ff @(posedge clk or posedge RESETN) begin
        if (RESETN) begin
            state_q       <= S_IDLE;
            clk_sync_q    <= '0;
            dat_sync_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            tmo_q         <= '0;
            brk_q         <= 1'b0;
            key_data_q    <= '0;
            last_key_q    <= '0;
            byte_valid_q  <= 1'b0;
            key_pressed_q <= 1'b0;
            frame_err_q   <= 1'b0;
            dly_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            clk_sync_q    <= {clk_sync_q[1:0], kbd.ps2_clk};
            dat_sync_q    <= {dat_sync_q[0], kbd.ps2_dat};
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            tmo_q         <= tmo_d;
            brk_q         <= brk_d;
            key_data_q    <= key_data_d;
            last_key_q    <= last_key_d;
            byte_valid_q  <= byte_valid_d;
            key_pressed_q <= key_pressed_d;
            frame_err_q   <= frame_err_d;
            dly_cnt_q     <= dly_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        tmo_d         = '0;
        brk_d         = brk_q;
        key_data_d    = key_data_q;
        last_key_d    = last_key_q;
        byte_valid_d  = 1'b0;
        key_pressed_d = 1'b0;
        frame_err_d   = 1'b0;

        // Watchdog on a stalled frame: restart from IDLE, partial byte dropped silently.
        if (state_q != S_IDLE && !ps2_fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
        end else begin
            if (state_q != S_IDLE && !ps2_fall) begin
                tmo_d = tmo_q + TW'(1);
            end
            if (ps2_fall) begin
                case (state_q)
                    S_IDLE: begin
                        if (!ps2_bit) begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                        end
                    end
                    S_DATA: begin
                        shift_d   = {ps2_bit, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_d   = ps2_bit;
                        state_d = S_STOP;
                    end
                    S_STOP: begin
                        state_d = S_IDLE;
                        // Odd parity over data+parity, and stop bit must be high.
                        if ((^{shift_q, par_q}) && ps2_bit) begin
                            byte_valid_d = 1'b1;
                            key_data_d   = shift_q;
                            if (shift_q == 8'hF0) begin
                                brk_d = 1'b1;
                            end else if (shift_q == 8'hE0) begin
                                brk_d = brk_q;
                            end else if (brk_q) begin
                                brk_d = 1'b0;   // this is the released key's code
                            end else begin
                                last_key_d    = shift_q;
                                key_pressed_d = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Saturating delay counter; dly_rst is its terminal-count flag.
        dly_cnt_d = (dly_cnt_q == RW'(RESET_DELAY_CYCLES)) ? dly_cnt_q : dly_cnt_q + RW'(1);
    end

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign kbd.key_data    = key_data_q;
    assign kbd.byte_valid  = byte_valid_q;
    assign kbd.key_pressed = key_pressed_q;
    assign kbd.last_key    = last_key_q;
    assign kbd.frame_err   = frame_err_q;
    assign kbd.hex0        = seg7(last_key_q[3:0]);
    assign kbd.hex1        = seg7(last_key_q[7:4]);
    assign kbd.dly_rst     = (dly_cnt_q == RW'(RESET_DELAY_CYCLES));
endmodule

// File: tb/tb_ps2_keyboard_frontend.sv
module tb_ps2_keyboard_frontend;
    localparam int TMO = 200;
    localparam int RD  = 16;
    localparam int HP  = 20;

    localparam logic [1:0] EV_VALID = 2'd0;
    localparam logic [1:0] EV_KEY   = 2'd1;
    localparam logic [1:0] EV_ERR   = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] b;
    } ev_t;

    logic clk = 1'b0;
    logic RESETN = 1'b1;

    ps2_keyboard_frontend_if kbd();

    ps2_keyboard_frontend #(.TIMEOUT_CYCLES(TMO), .RESET_DELAY_CYCLES(RD)) dut (
        .clk    (clk),
        .RESETN (RESETN),
        .kbd    (kbd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    ev_t        exp_q[$];
    logic       m_brk = 1'b0;
    logic [7:0] m_kd  = 8'h00;
    logic [7:0] m_lk  = 8'h00;
    bit         mon_en = 1'b0;
    int         n_bv = 0, n_kp = 0, n_fe = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame-level model: what one received frame should produce.
    task automatic model_frame(input logic [7:0] b, input bit good);
        ev_t ev;
        ev.b = b;
        if (!good) begin
            ev.kind = EV_ERR;
        end else if (b == 8'hF0) begin
            ev.kind = EV_VALID;
            m_brk   = 1'b1;
        end else if (b == 8'hE0) begin
            ev.kind = EV_VALID;
        end else if (m_brk) begin
            ev.kind = EV_VALID;
            m_brk   = 1'b0;
        end else begin
            ev.kind = EV_KEY;
        end
        exp_q.push_back(ev);
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            logic bv, kp, fe;
            ev_t  ev;
            bv = (kbd.byte_valid  === 1'b1);
            kp = (kbd.key_pressed === 1'b1);
            fe = (kbd.frame_err   === 1'b1);
            if (bv) n_bv++;
            if (kp) n_kp++;
            if (fe) n_fe++;
            if (bv || kp || fe) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, bv, kp, fe}, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    check("pulse_kind", {29'd0, bv, kp, fe},
                          (ev.kind == EV_ERR) ? 32'b001 : (ev.kind == EV_KEY) ? 32'b110 : 32'b100);
                    if (ev.kind != EV_ERR) m_kd = ev.b;
                    if (ev.kind == EV_KEY) m_lk = ev.b;
                end
            end
            check("key_data", {24'd0, kbd.key_data}, {24'd0, m_kd});
            check("last_key", {24'd0, kbd.last_key}, {24'd0, m_lk});
            check("hex0",     {25'd0, kbd.hex0}, {25'd0, seg_tab[m_lk[3:0]]});
            check("hex1",     {25'd0, kbd.hex1}, {25'd0, seg_tab[m_lk[7:4]]});
        end
    end

    task automatic send_bits(input logic [7:0] b, input bit par_bad, input logic stop, input int nbits);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ par_bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kbd.ps2_dat = bits[i];
            repeat (HP) @(posedge clk);
            kbd.ps2_clk = 1'b0;
            repeat (HP) @(posedge clk);
            kbd.ps2_clk = 1'b1;
        end
        kbd.ps2_dat = 1'b1;
        repeat (2 * HP) @(posedge clk);
    endtask

    task automatic frame(input logic [7:0] b, input bit par_bad, input logic stop);
        model_frame(b, !par_bad && (stop == 1'b1));
        send_bits(b, par_bad, stop, 11);
        check("drained", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        RESETN = 1'b1;
        exp_q.delete();
        m_brk = 1'b0;
        m_kd  = 8'h00;
        m_lk  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hex0", {25'd0, kbd.hex0}, 32'h40);
        check("rst_hex1", {25'd0, kbd.hex1}, 32'h40);
        check("rst_dly",  {31'd0, kbd.dly_rst}, 32'd0);
        @(negedge clk);
        RESETN = 1'b0;
        for (int i = 1; i <= RD; i++) begin
            @(posedge clk);
            #1;
            check("dly_ramp", {31'd0, kbd.dly_rst}, (i >= RD) ? 32'd1 : 32'd0);
        end
        repeat (30) @(posedge clk);
        #1;
        check("dly_hold", {31'd0, kbd.dly_rst}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int bv0, kp0, fe0;
        kbd.ps2_clk = 1'b1;
        kbd.ps2_dat = 1'b1;
        #1;
        mon_en = 1'b1;
        do_reset();

        // Plain make code
        bv0 = n_bv; kp0 = n_kp;
        frame(8'h1C, 1'b0, 1'b1);
        check("1C_bv", n_bv - bv0, 32'd1);
        check("1C_kp", n_kp - kp0, 32'd1);
        check("1C_key_data", {24'd0, kbd.key_data}, 32'h1C);
        check("1C_last_key", {24'd0, kbd.last_key}, 32'h1C);
        check("1C_hex0", {25'd0, kbd.hex0}, 32'h46);
        check("1C_hex1", {25'd0, kbd.hex1}, 32'h79);

        // Break sequence
        bv0 = n_bv; kp0 = n_kp;
        frame(8'hF0, 1'b0, 1'b1);
        frame(8'h1C, 1'b0, 1'b1);
        check("brk_bv", n_bv - bv0, 32'd2);
        check("brk_kp", n_kp - kp0, 32'd0);
        check("brk_last_key", {24'd0, kbd.last_key}, 32'h1C);

        // Extended prefix
        kp0 = n_kp;
        frame(8'hE0, 1'b0, 1'b1);
        check("E0_kp", n_kp - kp0, 32'd0);
        frame(8'h75, 1'b0, 1'b1);
        check("75_kp", n_kp - kp0, 32'd1);
        check("75_hex1", {25'd0, kbd.hex1}, 32'h78);
        check("75_hex0", {25'd0, kbd.hex0}, 32'h12);

        // Wrong parity
        bv0 = n_bv; fe0 = n_fe;
        frame(8'h32, 1'b1, 1'b1);
        check("par_fe", n_fe - fe0, 32'd1);
        check("par_bv", n_bv - bv0, 32'd0);
        check("par_last_key", {24'd0, kbd.last_key}, 32'h75);

        // Bad stop bit
        bv0 = n_bv; fe0 = n_fe;
        frame(8'h32, 1'b0, 1'b0);
        check("stop_fe", n_fe - fe0, 32'd1);
        check("stop_bv", n_bv - bv0, 32'd0);

        // Timeout abort, then clean frame
        bv0 = n_bv; fe0 = n_fe;
        send_bits(8'h55, 1'b0, 1'b1, 5);
        repeat (300) @(posedge clk);
        frame(8'h24, 1'b0, 1'b1);
        check("tmo_bv", n_bv - bv0, 32'd1);
        check("tmo_fe", n_fe - fe0, 32'd0);
        check("tmo_last_key", {24'd0, kbd.last_key}, 32'h24);
        check("tmo_hex1", {25'd0, kbd.hex1}, 32'h24);
        check("tmo_hex0", {25'd0, kbd.hex0}, 32'h19);

        // Reset mid-frame, then clean frame
        send_bits(8'hF0, 1'b0, 1'b1, 5);
        do_reset();
        check("mid_rst_last_key", {24'd0, kbd.last_key}, 32'h00);
        bv0 = n_bv; fe0 = n_fe; kp0 = n_kp;
        frame(8'h24, 1'b0, 1'b1);
        check("rst_bv", n_bv - bv0, 32'd1);
        check("rst_kp", n_kp - kp0, 32'd1);
        check("rst_fe", n_fe - fe0, 32'd0);
        check("rst_last_key", {24'd0, kbd.last_key}, 32'h24);
        check("rst_hex1", {25'd0, kbd.hex1}, 32'h24);
        check("rst_hex0", {25'd0, kbd.hex0}, 32'h19);
        check("final_dly", {31'd0, kbd.dly_rst}, 32'd1);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
